// File: rtl/alpha_pkg.sv
// alpha_pkg: shared constants and helpers for the alphanumeric row sequencer.
// Holds the character-cell geometry, the port widths and the glyph-row test
// used by alpha_row_sequencer and alpha_dot_shifter.
package alpha_pkg;

    // Character cell geometry
    localparam int unsigned CELL_ROWS     = 12;
    localparam int unsigned GLYPH_FIRST   = 3;
    localparam int unsigned GLYPH_LAST    = 9;
    localparam int unsigned DOTS_PER_CHAR = 8;

    // Port and internal widths
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned GLYPH_W = 6;
    localparam int unsigned ROW_W   = 4;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned DOT_W   = 3;

    // True when the cell scanline falls inside the 7-row glyph window
    function automatic logic in_glyph(input logic [ROW_W-1:0] row);
        return (row >= ROW_W'(GLYPH_FIRST)) && (row <= ROW_W'(GLYPH_LAST));
    endfunction

endpackage

// File: rtl/alpha_dot_shifter.sv
// alpha_dot_shifter: 8-dot pixel shift register with its dot counter and the
// load / underflow logic. A DotEn with the counter at its last dot loads a new
// row (ROM data, blank or inverted); other DotEn pulses shift MSB-first.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   dot_en                   pixel strobe
//   line_end, frame_start    scanline / field strobes, both beat dot_en
//   hold_valid               a character is waiting in the holding register
//   glyph_row                current scanline is inside the glyph window
//   inverse                  held character is to be drawn inverted
//   rom_pixels               ROM row for the held character
//   pixel                    current dot (shift register MSB)
//   underflow                sticky: a load found no character held
//   load_c                   a load happens at the coming edge
module alpha_dot_shifter
    import alpha_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             dot_en,
    input  logic             line_end,
    input  logic             frame_start,
    input  logic             hold_valid,
    input  logic             glyph_row,
    input  logic             inverse,
    input  logic [PIX_W-1:0] rom_pixels,
    output logic             pixel,
    output logic             underflow,
    output logic             load_c
);

    localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(DOTS_PER_CHAR - 1);

    logic [PIX_W-1:0] shreg;
    logic [DOT_W-1:0] dot_cnt;
    logic [PIX_W-1:0] load_val;

    // Load decision and value; an empty holding register always loads blank
    always_comb begin
        load_c   = 1'b0;
        load_val = '0;
        if (dot_en && !line_end && !frame_start && (dot_cnt == DOT_LAST)) begin
            load_c = 1'b1;
        end
        if (hold_valid) begin
            load_val = glyph_row ? rom_pixels : '0;
            load_val = load_val ^ {PIX_W{inverse}};
        end
    end

    // Shift register, dot counter and sticky underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            dot_cnt   <= DOT_LAST;
            underflow <= 1'b0;
        end else if (frame_start) begin
            shreg     <= '0;
            dot_cnt   <= DOT_LAST;
            underflow <= 1'b0;
        end else if (line_end) begin
            shreg   <= '0;
            dot_cnt <= DOT_LAST;
        end else if (load_c) begin
            shreg   <= load_val;
            dot_cnt <= '0;
            if (!hold_valid) begin
                underflow <= 1'b1;
            end
        end else if (dot_en) begin
            shreg   <= {shreg[PIX_W-2:0], 1'b0};
            dot_cnt <= dot_cnt + DOT_W'(1);
        end
    end

    assign pixel = shreg[PIX_W-1];

endmodule

// File: rtl/alpha_row_sequencer.sv
// alpha_row_sequencer: alphanumeric display row sequencer. Holds one character,
// addresses the external character ROM by glyph index and glyph row, tracks the
// scanline within the 12-line cell and feeds alpha_dot_shifter for serial dots.
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   DotEn             pixel strobe
//   LineEnd           end-of-scanline strobe (advances CellRow)
//   FrameStart        start-of-field strobe (CellRow to 0, clears Underflow)
//   CharCode          [5:0] glyph, [6] inverse, [7] ignored
//   CharValid         CharCode valid; CharReady = holding register empty
//   RomData, RomRow   ROM address; RomPixels = ROM row data, MSB first
//   Pixel             current dot, 1 = foreground
//   CellRow           scanline within the cell, 0..11
//   Underflow         sticky, a load found no character held
// Build option: define ALPHA_INVERSE_EN to honour CharCode[6] (inverse video).
module alpha_row_sequencer
    import alpha_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               DotEn,
    input  logic               LineEnd,
    input  logic               FrameStart,
    input  logic [CHAR_W-1:0]  CharCode,
    input  logic               CharValid,
    output logic               CharReady,
    output logic [GLYPH_W-1:0] RomData,
    output logic [ROW_W-1:0]   RomRow,
    input  logic [PIX_W-1:0]   RomPixels,
    output logic               Pixel,
    output logic [ROW_W-1:0]   CellRow,
    output logic               Underflow
);

    logic               hold_valid;
    logic [GLYPH_W-1:0] hold_glyph;
    logic               hold_inverse;
    logic [ROW_W-1:0]   cell_row;
    logic               accept;
    logic               load;
    logic               glyph_row;

    assign accept = CharValid && !hold_valid;

    // Holding register: a load empties it, an accept in the same cycle refills it
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_valid <= 1'b0;
            hold_glyph <= '0;
        end else if (accept) begin
            hold_valid <= 1'b1;
            hold_glyph <= CharCode[GLYPH_W-1:0];
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef ALPHA_INVERSE_EN
    logic hold_inv_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_inv_q <= 1'b0;
        end else if (accept) begin
            hold_inv_q <= CharCode[6];
        end
    end

    assign hold_inverse = hold_inv_q;

    logic unused_charcode;
    assign unused_charcode = CharCode[7];
`else
    assign hold_inverse = 1'b0;

    logic unused_charcode;
    assign unused_charcode = ^CharCode[7:6];
`endif

    // Scanline within the cell; FrameStart beats LineEnd
    always_ff @(posedge Clk) begin
        if (Reset || FrameStart) begin
            cell_row <= '0;
        end else if (LineEnd) begin
            if (cell_row == ROW_W'(CELL_ROWS - 1)) begin
                cell_row <= '0;
            end else begin
                cell_row <= cell_row + ROW_W'(1);
            end
        end
    end

    // ROM addressing
    always_comb begin
        glyph_row = in_glyph(cell_row);
        RomRow    = glyph_row ? (cell_row - ROW_W'(GLYPH_FIRST)) : '0;
    end

    assign RomData   = hold_glyph;
    assign CharReady = !hold_valid;
    assign CellRow   = cell_row;

    alpha_dot_shifter u_dot_shifter (
        .clk         (Clk),
        .reset       (Reset),
        .dot_en      (DotEn),
        .line_end    (LineEnd),
        .frame_start (FrameStart),
        .hold_valid  (hold_valid),
        .glyph_row   (glyph_row),
        .inverse     (hold_inverse),
        .rom_pixels  (RomPixels),
        .pixel       (Pixel),
        .underflow   (Underflow),
        .load_c      (load)
    );

endmodule

// File: tb/tb_alpha_row_sequencer.sv
// tb_alpha_row_sequencer: directed scenarios plus randomized traffic for
// alpha_row_sequencer, checked every cycle against a behavioural model that
// keeps pending dots as a queue of bits and the cell row as an integer.
module tb_alpha_row_sequencer;

`ifdef ALPHA_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic       Clk;
    logic       Reset;
    logic       DotEn;
    logic       LineEnd;
    logic       FrameStart;
    logic [7:0] CharCode;
    logic       CharValid;
    logic       CharReady;
    logic [5:0] RomData;
    logic [3:0] RomRow;
    logic [7:0] RomPixels;
    logic       Pixel;
    logic [3:0] CellRow;
    logic       Underflow;

    alpha_row_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DotEn      (DotEn),
        .LineEnd    (LineEnd),
        .FrameStart (FrameStart),
        .CharCode   (CharCode),
        .CharValid  (CharValid),
        .CharReady  (CharReady),
        .RomData    (RomData),
        .RomRow     (RomRow),
        .RomPixels  (RomPixels),
        .Pixel      (Pixel),
        .CellRow    (CellRow),
        .Underflow  (Underflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Character ROM model; glyph 1 row 0 is 8'h08
    function automatic logic [7:0] rom_f(input logic [5:0] g, input logic [3:0] r);
        if (g == 6'd1 && r == 4'd0) return 8'h08;
        return 8'((int'(g) * 37) ^ (int'(r) * 91) ^ 8'h5A);
    endfunction

    assign RomPixels = rom_f(RomData, RomRow);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model state
    bit       m_hold;
    bit [5:0] m_glyph;
    bit       m_inv;
    bit       m_q[$];
    int       m_left;   // DotEn pulses left before the next load
    int       m_row;
    bit       m_uf;

    logic obs_pix, obs_ready, obs_uf;
    logic [3:0] obs_row, obs_romrow;

    function automatic bit m_in_glyph();
        return m_row >= 3 && m_row <= 9;
    endfunction

    task automatic model_update(input logic r, de, le, fs, cv, input logic [7:0] cc);
        bit acc, did_load;
        bit [7:0] val;
        if (r) begin
            m_hold = 0; m_glyph = 0; m_inv = 0; m_q.delete();
            m_left = 0; m_row = 0; m_uf = 0;
            return;
        end
        acc = cv && !m_hold;
        did_load = 0;
        if (fs) begin
            m_row = 0; m_q.delete(); m_left = 0; m_uf = 0;
        end else if (le) begin
            m_row = (m_row + 1) % 12; m_q.delete(); m_left = 0;
        end else if (de) begin
            if (m_left == 0) begin
                did_load = 1;
                if (!m_hold) begin
                    val = 8'h00;
                    m_uf = 1;
                end else begin
                    val = m_in_glyph() ? rom_f(m_glyph, 4'(m_row - 3)) : 8'h00;
                    if (m_inv) val = ~val;
                end
                m_q.delete();
                for (int b = 7; b >= 0; b--) m_q.push_back(val[b]);
                m_left = 7;
            end else begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                m_left--;
            end
        end
        if (acc) begin
            m_hold = 1; m_glyph = cc[5:0]; m_inv = INV_EN && cc[6];
        end else if (did_load) begin
            m_hold = 0;
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model
    task automatic step(input logic r, de, le, fs, cv, input logic [7:0] cc);
        Reset = r; DotEn = de; LineEnd = le; FrameStart = fs;
        CharValid = cv; CharCode = cc;
        @(negedge Clk);
        obs_pix = Pixel; obs_ready = CharReady; obs_uf = Underflow;
        obs_row = CellRow; obs_romrow = RomRow;
        check("char_ready", 32'(CharReady), 32'(!m_hold));
        check("rom_data", 32'(RomData), 32'(m_glyph));
        check("rom_row", 32'(RomRow), m_in_glyph() ? 32'(m_row - 3) : 32'd0);
        check("pixel", 32'(Pixel), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        check("cell_row", 32'(CellRow), 32'(m_row));
        check("underflow", 32'(Underflow), 32'(m_uf));
        @(posedge Clk);
        model_update(r, de, le, fs, cv, cc);
        #1;
    endtask

    logic ready_after_load;

    // Load DotEn then eight samples (seven shifts); returns the dot sequence
    task automatic dots8(input logic cv, input logic [7:0] cc, output logic [7:0] seq);
        step(0, 1, 0, 0, cv, cc);
        seq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(0, 1'(i < 7), 0, 0, cv, cc);
            if (i == 0) ready_after_load = obs_ready;
            seq = {seq[6:0], obs_pix};
        end
    endtask

    logic [7:0] seq;

    initial begin
        Reset = 1; DotEn = 0; LineEnd = 0; FrameStart = 0; CharValid = 0; CharCode = 0;
        repeat (2) @(posedge Clk);
        #1;
        model_update(1, 0, 0, 0, 0, 0);

        // Reset values
        step(1, 0, 0, 0, 0, 8'h00);

        // Glyph row 0 of glyph 1
        step(0, 0, 0, 1, 0, 8'h00);
        repeat (3) step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h01);
        dots8(1, 8'h01, seq);
        check("glyph_seq", 32'(seq), 32'h08);
        check("glyph_romrow", 32'(obs_romrow), 32'd0);

        // Blank scanline with a character held
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        dots8(1, 8'h01, seq);
        check("blank_seq", 32'(seq), 32'h00);
        check("blank_hold_clr", 32'(ready_after_load), 32'd1);

        // Underflow, then FrameStart clears it
        dots8(0, 8'h00, seq);
        dots8(0, 8'h00, seq);
        check("uf_seq", 32'(seq), 32'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("uf_set", 32'(obs_uf), 32'd1);
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("uf_clr", 32'(obs_uf), 32'd0);

        // Cell row wrap and FrameStart over LineEnd
        for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("row_wrap", 32'(obs_row), 32'd0);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 1, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("fs_over_le", 32'(obs_row), 32'd0);

`ifdef ALPHA_INVERSE_EN
        // Inverse video inside and outside the glyph window
        repeat (3) step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h41);
        dots8(1, 8'h41, seq);
        check("inv_glyph_seq", 32'(seq), 32'hF7);
        repeat (7) step(0, 0, 1, 0, 0, 8'h00);
        dots8(0, 8'h00, seq);
        check("inv_blank_seq", 32'(seq), 32'hFF);
        step(0, 0, 0, 1, 0, 8'h00);
`endif

        // Reset mid-character, then a fresh character loads on the next DotEn
        repeat (3) step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h05);
        step(0, 1, 0, 0, 0, 8'h00);
        repeat (4) step(0, 1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("rst_ready", 32'(obs_ready), 32'd1);
        check("rst_pixel", 32'(obs_pix), 32'd0);
        check("rst_row", 32'(obs_row), 32'd0);
        step(0, 0, 0, 0, 1, 8'h01);
        step(0, 1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        check("rst_reload", 32'(obs_ready), 32'd1);
        check("rst_no_uf", 32'(obs_uf), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 9) < 6),
                 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
